// File: rtl/mips_mem_pkg.sv
`default_nettype none
// ============================================================================
// Package     : mips_mem_pkg
// Description : Shared memory-side types and constants for the MEM stage.
// Revision    : 1.0 - initial release
// ============================================================================
package mips_mem_pkg;

    localparam int          c_DATA_WIDTH    = 32;
    localparam logic [31:0] c_DATA_SEG_BASE = 32'h1001_0000;

    typedef struct packed {
        logic [c_DATA_WIDTH-1:0] addr;
        logic [c_DATA_WIDTH-1:0] data;
        logic                    valid;
    } swb_entry_t;

endpackage : mips_mem_pkg
`default_nettype wire

// File: rtl/store_write_buffer_if.sv
`default_nettype none
// ============================================================================
// Interface   : store_write_buffer_if
// Description : MEM-stage and data-memory signals around the store buffer.
// Revision    : 1.0 - initial release
// ============================================================================
interface store_write_buffer_if
    import mips_mem_pkg::*;
#(
    parameter int DATA_WIDTH = c_DATA_WIDTH
);

    logic                  store_valid;
    logic [DATA_WIDTH-1:0] store_addr;
    logic [DATA_WIDTH-1:0] store_data;
    logic                  store_ready;
    logic                  stall;
    logic                  load_req;
    logic [DATA_WIDTH-1:0] load_addr;
    logic [DATA_WIDTH-1:0] load_data;
    logic                  buffer_empty;
    logic                  mem_write;
    logic                  mem_read;
    logic [DATA_WIDTH-1:0] mem_address;
    logic [DATA_WIDTH-1:0] mem_write_data;
    logic [DATA_WIDTH-1:0] mem_read_data;

    // Pipeline and data memory side: drives requests, returns read data.
    modport master (
        output store_valid, store_addr, store_data, load_req, load_addr,
        output mem_read_data,
        input  store_ready, stall, load_data, buffer_empty,
        input  mem_write, mem_read, mem_address, mem_write_data
    );

    // The store buffer itself.
    modport slave (
        input  store_valid, store_addr, store_data, load_req, load_addr,
        input  mem_read_data,
        output store_ready, stall, load_data, buffer_empty,
        output mem_write, mem_read, mem_address, mem_write_data
    );

endinterface : store_write_buffer_if
`default_nettype wire

// File: rtl/swb_forward_match.sv
`default_nettype none
// ============================================================================
// Module      : swb_forward_match
// Description : Word-address match of a load against buffered stores,
//               youngest matching entry wins.
// Revision    : 1.0 - initial release
// ============================================================================
module swb_forward_match
    import mips_mem_pkg::*;
#(
    parameter int DEPTH     = 4,
    parameter int PTR_WIDTH = 2
) (
    input  logic [c_DATA_WIDTH-3:0] i_loadWord,
    input  swb_entry_t              i_entries [DEPTH],
    input  logic [PTR_WIDTH-1:0]    i_head,
    output logic                    o_hit,
    output logic [c_DATA_WIDTH-1:0] o_data
);

    logic [1:0] w_unusedLowBits;

    // Walk oldest to youngest so a later (younger) match overrides.
    always_comb begin
        o_hit           = 1'b0;
        o_data          = '0;
        w_unusedLowBits = '0;
        for (int k = 0; k < DEPTH; k++) begin
            logic [PTR_WIDTH-1:0] w_idx;
            w_idx           = i_head + PTR_WIDTH'(k);
            w_unusedLowBits = w_unusedLowBits ^ i_entries[w_idx].addr[1:0];
            if (i_entries[w_idx].valid &&
                (i_entries[w_idx].addr[c_DATA_WIDTH-1:2] == i_loadWord)) begin
                o_hit  = 1'b1;
                o_data = i_entries[w_idx].data;
            end
        end
    end

endmodule : swb_forward_match
`default_nettype wire

// File: rtl/store_write_buffer.sv
`default_nettype none
// ============================================================================
// Module      : store_write_buffer
// Description : Store FIFO between MEM stage and data memory; drains on
//               load-free cycles and forwards buffered data to loads.
// Revision    : 1.0 - initial release
// ============================================================================
module store_write_buffer
    import mips_mem_pkg::*;
#(
    parameter int DATA_WIDTH = c_DATA_WIDTH,
    parameter int DEPTH      = 4,
    parameter int PTR_WIDTH  = 2
) (
    input  logic          clk,
    input  logic          reset,
    store_write_buffer_if.slave bus
);

    localparam logic [PTR_WIDTH:0] c_FULL_COUNT = DEPTH[PTR_WIDTH:0];

    swb_entry_t             r_entries [DEPTH];
    logic [PTR_WIDTH-1:0]   r_head;
    logic [PTR_WIDTH-1:0]   r_tail;
    logic [PTR_WIDTH:0]     r_count;

    logic                   w_ready;
    logic                   w_enqueue;
    logic                   w_drain;
    logic                   w_hit;
    logic [DATA_WIDTH-1:0]  w_fwdData;
    swb_entry_t             w_headEntry;

    assign w_ready     = (r_count < c_FULL_COUNT);
    assign w_enqueue   = bus.store_valid && w_ready;
    // Reset blocks the drain so discarded stores never reach memory.
    assign w_drain     = !reset && !bus.load_req && (r_count != '0);
    assign w_headEntry = r_entries[r_head];

    swb_forward_match #(
        .DEPTH     (DEPTH),
        .PTR_WIDTH (PTR_WIDTH)
    ) u_forward_match (
        .i_loadWord (bus.load_addr[DATA_WIDTH-1:2]),
        .i_entries  (r_entries),
        .i_head     (r_head),
        .o_hit      (w_hit),
        .o_data     (w_fwdData)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_entries[i] <= '0;
            end
        end else begin
            if (w_enqueue) begin
                r_entries[r_tail] <= '{addr: bus.store_addr, data: bus.store_data, valid: 1'b1};
                r_tail            <= r_tail + PTR_WIDTH'(1);
            end
            if (w_drain) begin
                r_entries[r_head].valid <= 1'b0;
                r_head                  <= r_head + PTR_WIDTH'(1);
            end
            case ({w_enqueue, w_drain})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign bus.store_ready  = w_ready;
    assign bus.stall        = bus.store_valid && !w_ready;
    assign bus.buffer_empty = (r_count == '0);
    assign bus.mem_read     = bus.load_req;
    assign bus.mem_write    = w_drain;

    always_comb begin
        bus.mem_address    = '0;
        bus.mem_write_data = '0;
        bus.load_data      = '0;
        if (bus.load_req) begin
            bus.mem_address = bus.load_addr;
            bus.load_data   = w_hit ? w_fwdData : bus.mem_read_data;
        end else if (w_drain) begin
            bus.mem_address    = w_headEntry.addr;
            bus.mem_write_data = w_headEntry.data;
        end
    end

endmodule : store_write_buffer
`default_nettype wire

// File: tb/tb_store_write_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_store_write_buffer
// Description : Directed vector bench for store_write_buffer with a simple
//               word-addressed data memory model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_store_write_buffer;

    logic clk;
    logic reset;

    store_write_buffer_if #(.DATA_WIDTH(32)) bus ();

    store_write_buffer #(
        .DATA_WIDTH (32),
        .DEPTH      (4),
        .PTR_WIDTH  (2)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Data memory model: 16 words at 0x1001_0000, combinational read.
    logic [31:0] memArr [16];
    logic [31:0] logAddr [$];
    logic [31:0] logData [$];

    assign bus.mem_read_data = memArr[bus.mem_address[5:2]];

    always @(posedge clk) begin
        if (bus.mem_write) begin
            memArr[bus.mem_address[5:2]] <= bus.mem_write_data;
            logAddr.push_back(bus.mem_address);
            logData.push_back(bus.mem_write_data);
        end
    end

    typedef struct {
        logic        sv;
        logic [31:0] sa;
        logic [31:0] sd;
        logic        lr;
        logic [31:0] la;
        logic        eReady;
        logic        eStall;
        logic        eEmpty;
        logic        eMw;
        logic        eMr;
        logic [31:0] eAddr;
        logic [31:0] eWd;
        logic [31:0] eLd;
    } vec_t;

    vec_t vecs [16];
    int   nChecks;
    int   nFail;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic sv, input logic [31:0] sa, input logic [31:0] sd,
                         input logic lr, input logic [31:0] la);
        bus.store_valid = sv;
        bus.store_addr  = sa;
        bus.store_data  = sd;
        bus.load_req    = lr;
        bus.load_addr   = la;
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    localparam logic [31:0] A0 = 32'h1001_0000;
    localparam logic [31:0] A4 = 32'h1001_0004;
    localparam logic [31:0] A8 = 32'h1001_0008;
    localparam logic [31:0] LX = 32'h1001_003C;

    initial begin
        int logBase;
        nChecks = 0;
        nFail   = 0;
        for (int i = 0; i < 16; i++) memArr[i] = '0;
        memArr[2] = 32'h0000_55AA;

        //            sv  sa                sd             lr  la               rdy stl emp mw  mr  addr             wd             ld
        vecs[0]  = '{1'b0, 32'h0,           32'h0,         1'b0, 32'h0,           1'b1,1'b0,1'b1,1'b0,1'b0, 32'h0,           32'h0,         32'h0};
        vecs[1]  = '{1'b1, A0,              32'hDEADBEEF,  1'b0, 32'h0,           1'b1,1'b0,1'b1,1'b0,1'b0, 32'h0,           32'h0,         32'h0};
        vecs[2]  = '{1'b0, 32'h0,           32'h0,         1'b0, 32'h0,           1'b1,1'b0,1'b0,1'b1,1'b0, A0,              32'hDEADBEEF,  32'h0};
        vecs[3]  = '{1'b0, 32'h0,           32'h0,         1'b0, 32'h0,           1'b1,1'b0,1'b1,1'b0,1'b0, 32'h0,           32'h0,         32'h0};
        vecs[4]  = '{1'b1, A4,              32'h11,        1'b0, 32'h0,           1'b1,1'b0,1'b1,1'b0,1'b0, 32'h0,           32'h0,         32'h0};
        vecs[5]  = '{1'b1, A4,              32'h22,        1'b1, A4,              1'b1,1'b0,1'b0,1'b0,1'b1, A4,              32'h0,         32'h11};
        vecs[6]  = '{1'b0, 32'h0,           32'h0,         1'b1, A4,              1'b1,1'b0,1'b0,1'b0,1'b1, A4,              32'h0,         32'h22};
        vecs[7]  = '{1'b0, 32'h0,           32'h0,         1'b1, A4,              1'b1,1'b0,1'b0,1'b0,1'b1, A4,              32'h0,         32'h22};
        vecs[8]  = '{1'b0, 32'h0,           32'h0,         1'b1, A8,              1'b1,1'b0,1'b0,1'b0,1'b1, A8,              32'h0,         32'h55AA};
        vecs[9]  = '{1'b0, 32'h0,           32'h0,         1'b0, 32'h0,           1'b1,1'b0,1'b0,1'b1,1'b0, A4,              32'h11,        32'h0};
        vecs[10] = '{1'b0, 32'h0,           32'h0,         1'b0, 32'h0,           1'b1,1'b0,1'b0,1'b1,1'b0, A4,              32'h22,        32'h0};
        vecs[11] = '{1'b0, 32'h0,           32'h0,         1'b1, A4,              1'b1,1'b0,1'b1,1'b0,1'b1, A4,              32'h0,         32'h22};
        vecs[12] = '{1'b1, 32'h1001000B,    32'h77,        1'b1, 32'h10010009,    1'b1,1'b0,1'b1,1'b0,1'b1, 32'h10010009,    32'h0,         32'h55AA};
        vecs[13] = '{1'b0, 32'h0,           32'h0,         1'b1, 32'h1001000A,    1'b1,1'b0,1'b0,1'b0,1'b1, 32'h1001000A,    32'h0,         32'h77};
        vecs[14] = '{1'b0, 32'h0,           32'h0,         1'b0, 32'h0,           1'b1,1'b0,1'b0,1'b1,1'b0, 32'h1001000B,    32'h77,        32'h0};
        vecs[15] = '{1'b0, 32'h0,           32'h0,         1'b0, 32'h0,           1'b1,1'b0,1'b1,1'b0,1'b0, 32'h0,           32'h0,         32'h0};

        reset = 1'b1;
        drive(1'b0, '0, '0, 1'b0, '0);
        nextCycle();
        nextCycle();
        reset = 1'b0;

        for (int v = 0; v < 16; v++) begin
            drive(vecs[v].sv, vecs[v].sa, vecs[v].sd, vecs[v].lr, vecs[v].la);
            @(negedge clk);
            check($sformatf("v%0d store_ready", v),    {31'b0, bus.store_ready},  {31'b0, vecs[v].eReady});
            check($sformatf("v%0d stall", v),          {31'b0, bus.stall},        {31'b0, vecs[v].eStall});
            check($sformatf("v%0d buffer_empty", v),   {31'b0, bus.buffer_empty}, {31'b0, vecs[v].eEmpty});
            check($sformatf("v%0d mem_write", v),      {31'b0, bus.mem_write},    {31'b0, vecs[v].eMw});
            check($sformatf("v%0d mem_read", v),       {31'b0, bus.mem_read},     {31'b0, vecs[v].eMr});
            check($sformatf("v%0d mem_address", v),    bus.mem_address,           vecs[v].eAddr);
            check($sformatf("v%0d mem_write_data", v), bus.mem_write_data,        vecs[v].eWd);
            check($sformatf("v%0d load_data", v),      bus.load_data,             vecs[v].eLd);
            nextCycle();
        end
        check("mem word0 after drain", memArr[0], 32'hDEADBEEF);
        check("mem word1 after drain", memArr[1], 32'h22);
        check("mem word2 low-bit addr", memArr[2], 32'h77);

        // Fill under a held load, stall on the fifth store, then ordered drain.
        logBase = logAddr.size();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'h1001_0010 + 32'(4 * i), 32'hA1 + 32'(i), 1'b1, LX);
            @(negedge clk);
            check($sformatf("fill%0d stall", i),     {31'b0, bus.stall},     32'h0);
            check($sformatf("fill%0d mem_write", i), {31'b0, bus.mem_write}, 32'h0);
            check($sformatf("fill%0d mem_read", i),  {31'b0, bus.mem_read},  32'h1);
            nextCycle();
        end
        drive(1'b1, 32'h1001_0020, 32'hA5, 1'b0, '0);
        @(negedge clk);
        check("full store_ready", {31'b0, bus.store_ready}, 32'h0);
        check("full stall",       {31'b0, bus.stall},       32'h1);
        check("full mem_write",   {31'b0, bus.mem_write},   32'h1);
        check("full drain addr",  bus.mem_address,          32'h1001_0010);
        check("full drain data",  bus.mem_write_data,       32'hA1);
        nextCycle();
        @(negedge clk);
        check("retry stall",      {31'b0, bus.stall},       32'h0);
        check("retry store_ready",{31'b0, bus.store_ready}, 32'h1);
        check("retry drain addr", bus.mem_address,          32'h1001_0014);
        nextCycle();
        drive(1'b0, '0, '0, 1'b0, '0);
        for (int i = 2; i < 5; i++) begin
            @(negedge clk);
            check($sformatf("drain%0d mem_write", i), {31'b0, bus.mem_write}, 32'h1);
            check($sformatf("drain%0d addr", i),      bus.mem_address,        32'h1001_0010 + 32'(4 * i));
            nextCycle();
        end
        @(negedge clk);
        check("drained buffer_empty", {31'b0, bus.buffer_empty}, 32'h1);
        check("drained mem_write",    {31'b0, bus.mem_write},    32'h0);
        check("drain log count", 32'(logAddr.size() - logBase), 32'd5);
        for (int i = 0; i < 5; i++) begin
            if (logBase + i < logAddr.size()) begin
                check($sformatf("drain order addr%0d", i), logAddr[logBase + i], 32'h1001_0010 + 32'(4 * i));
                check($sformatf("drain order data%0d", i), logData[logBase + i], 32'hA1 + 32'(i));
            end
        end
        nextCycle();

        // Reset with three stores pending: they must be discarded.
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'h1001_0030 + 32'(4 * i), 32'hC1 + 32'(i), 1'b1, LX);
            nextCycle();
        end
        logBase = logAddr.size();
        drive(1'b0, '0, '0, 1'b0, '0);
        reset = 1'b1;
        @(negedge clk);
        check("pre-reset buffer_empty", {31'b0, bus.buffer_empty}, 32'h0);
        check("in-reset mem_write",     {31'b0, bus.mem_write},    32'h0);
        nextCycle();
        reset = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check($sformatf("post-reset%0d buffer_empty", i), {31'b0, bus.buffer_empty}, 32'h1);
            check($sformatf("post-reset%0d store_ready", i),  {31'b0, bus.store_ready},  32'h1);
            check($sformatf("post-reset%0d mem_write", i),    {31'b0, bus.mem_write},    32'h0);
            nextCycle();
        end
        check("post-reset log count", 32'(logAddr.size() - logBase), 32'd0);
        check("post-reset mem word12", memArr[12], 32'h0);
        check("post-reset mem word14", memArr[14], 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule : tb_store_write_buffer
`default_nettype wire
